// File: rtl/fifo_stream_reader.sv
// Drain stage for a registered-read FIFO: 3-entry skid buffer presenting words on a valid/ready stream.
// Optional handshake counter output xfer_cnt is built when FIFO_RD_XFER_CNT_EN is defined.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_XFER_CNT_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);

    localparam int DEPTH = 3;

    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  inflight;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [DATA_WIDTH-1:0] buf_mem [DEPTH];
    logic [2:0]            committed;
    logic                  pop;
    logic                  capture;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one arriving next cycle; issuing only while this
    // is <= 2 is what keeps a capture from ever landing on a full buffer.
    assign committed = {1'b0, occ} + {2'b0, inflight};
    assign fifo_r_en = rst & ~fifo_empty & (committed <= 3'd2);

    assign capture = inflight;
    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        occ_next = occ;
        occ_next = occ + {1'b0, capture} - {1'b0, pop};
    end

    always_comb begin
        m_data = buf_mem[0];
        case (head)
            2'd1:    m_data = buf_mem[1];
            2'd2:    m_data = buf_mem[2];
            default: m_data = buf_mem[0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 2'd0;
            tail     <= 2'd0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_r_en;
            if (capture) tail <= ptr_inc(tail);
            if (pop)     head <= ptr_inc(head);
        end
    end

    // NOTE: the buffer is deliberately reset so m_data reads 0 out of reset; it is only three words wide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (capture && (tail == 2'(i))) buf_mem[i] <= fifo_data;
            end
        end
    end

`ifdef FIFO_RD_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     xfer_cnt_q <= 16'h0000;
        else if (pop) xfer_cnt_q <= xfer_cnt_q + 16'h0001;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO source, in-order expected-word queue and stream protocol monitor.
module tb_fifo_stream_reader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_empty = 1'b1;
    logic         fifo_r_en;
    logic [W-1:0] fifo_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
`ifdef FIFO_RD_XFER_CNT_EN
    logic [15:0]  xfer_cnt;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_XFER_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fifo_q [$];   // contents of the upstream FIFO
    logic [W-1:0] exp_q  [$];   // words the stream must deliver, in order

    int          cyc = 0;
    int          reads, hs, gaps, last_rd_cyc, first_valid_cyc, last_hs_cyc;
    logic [15:0] hs_total = 16'h0000;
    logic        prev_pending = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic clear_stats();
        reads = 0; hs = 0; gaps = 0;
        last_rd_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: observe at the falling edge, update the FIFO model just after the rising edge.
    task automatic step();
        logic rd;
        logic [W-1:0] exp;
        @(negedge clk);
        rd = fifo_r_en;
        if (rd === 1'b1) begin
            checks++;
            if (fifo_empty) begin
                errors++;
                $display("FAIL rd_while_empty cyc=%0d: fifo_r_en=1, expected 0", cyc);
            end
            reads++;
            last_rd_cyc = cyc;
        end
        if (prev_pending) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
                errors++;
                $display("FAIL stall_stable cyc=%0d: valid=%b data=%h, expected valid=1 data=%h",
                         cyc, m_valid, m_data, prev_data);
            end
        end
`ifdef FIFO_RD_XFER_CNT_EN
        checks++;
        if (xfer_cnt !== hs_total) begin
            errors++;
            $display("FAIL xfer_cnt cyc=%0d: got %h, expected %h", cyc, xfer_cnt, hs_total);
        end
`endif
        if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid === 1'b1 && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_data cyc=%0d: got %h, expected no word", cyc, m_data);
            end else begin
                exp = exp_q.pop_front();
                if (m_data !== exp) begin
                    errors++;
                    $display("FAIL stream_data cyc=%0d: got %h, expected %h", cyc, m_data, exp);
                end
            end
            if (last_hs_cyc >= 0 && cyc != last_hs_cyc + 1) gaps++;
            last_hs_cyc = cyc;
            hs++;
            hs_total = hs_total + 16'h0001;
        end
        prev_pending = (m_valid === 1'b1) && !m_ready;
        prev_data    = m_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rd === 1'b1 && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic model_reset();
        fifo_q.delete();
        exp_q.delete();
        fifo_data    = '0;
        fifo_empty   = 1'b1;
        prev_pending = 1'b0;
        hs_total     = 16'h0000;
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: r_en=%b valid=%b data=%h, expected 0 0 00", fifo_r_en, m_valid, m_data);
        end
`ifdef FIFO_RD_XFER_CNT_EN
        checks++;
        if (xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_xfer_cnt: got %h, expected 0000", xfer_cnt);
        end
`endif
        repeat (3) step();
        rst = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0) begin
                errors++;
                $display("FAIL idle_outputs: r_en=%b valid=%b data=%h, expected 0 0 00", fifo_r_en, m_valid, m_data);
            end
        end
    endtask

    task automatic test_single_word();
        int push_cyc;
        clear_stats();
        m_ready = 1'b1;
        push_word(8'hA5);
        push_cyc = cyc;
        for (int i = 0; i < 10; i++) step();
        expect_int("single_reads", reads, 1);
        expect_int("single_read_cycle", last_rd_cyc, push_cyc);
        expect_int("single_fill_latency", first_valid_cyc - last_rd_cyc, 2);
        expect_int("single_handshakes", hs, 1);
    endtask

    task automatic test_streaming();
        clear_stats();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        for (int i = 0; i < 40 && hs < 8; i++) step();
        expect_int("stream_handshakes", hs, 8);
        expect_int("stream_gaps", gaps, 0);
        expect_int("stream_leftover", exp_q.size(), 0);
    endtask

    task automatic test_backpressure();
        clear_stats();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        repeat (10) step();
        expect_int("bp_reads_stalled", reads, 3);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
            errors++;
            $display("FAIL bp_head: valid=%b data=%h, expected valid=1 data=01", m_valid, m_data);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 40 && hs < 8; i++) step();
        expect_int("bp_handshakes", hs, 8);
        expect_int("bp_reads_total", reads, 8);
        expect_int("bp_release_gaps", gaps, 0);
        repeat (3) step();
        expect_int("bp_no_extra", hs, 8);
    endtask

    task automatic test_empty_boundary();
        clear_stats();
        push_word(8'h5C);
        push_word(8'hC3);
        for (int i = 0; i < 16; i++) begin
            m_ready = ~i[0];
            step();
        end
        m_ready = 1'b1;
        repeat (3) step();
        expect_int("empty_handshakes", hs, 2);
        expect_int("empty_reads", reads, 2);
    endtask

    task automatic test_random();
        int pushed;
        clear_stats();
        pushed = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
                push_word(8'($urandom));
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            step();
            if (reads - hs > 3) begin
                checks++;
                errors++;
                $display("FAIL rand_occupancy cyc=%0d: outstanding=%0d, expected <= 3", cyc, reads - hs);
            end
        end
        m_ready = 1'b1;
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) step();
        expect_int("rand_handshakes", hs, pushed);
        expect_int("rand_leftover", exp_q.size(), 0);
    endtask

    task automatic test_reset_midop();
        clear_stats();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'hE0 + 8'(i));
        for (int i = 0; i < 20 && reads < 3; i++) step();
        expect_int("midop_reads_before_reset", reads, 3);
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (m_valid !== 1'b0 || fifo_r_en !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL midop_reset: valid=%b r_en=%b data=%h, expected 0 0 00", m_valid, fifo_r_en, m_data);
        end
`ifdef FIFO_RD_XFER_CNT_EN
        checks++;
        if (xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL midop_xfer_cnt: got %h, expected 0000", xfer_cnt);
        end
`endif
        repeat (2) step();
        rst = 1'b1;
        clear_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
        for (int i = 0; i < 30 && hs < 4; i++) step();
        expect_int("midop_refill_handshakes", hs, 4);
        expect_int("midop_refill_leftover", exp_q.size(), 0);
    endtask

`ifdef FIFO_RD_XFER_CNT_EN
    task automatic test_counter_wrap();
        clear_stats();
        m_ready = 1'b0;
        repeat (3) step();
        force dut.xfer_cnt_q = 16'hFFFE;
        hs_total = 16'hFFFE;
        step();
        release dut.xfer_cnt_q;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(8'h70 + 8'(i));
        for (int i = 0; i < 20 && hs < 3; i++) step();
        step();
        expect_int("wrap_handshakes", hs, 3);
        checks++;
        if (xfer_cnt !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_final: got %h, expected 0001", xfer_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_random();
        test_reset_midop();
`ifdef FIFO_RD_XFER_CNT_EN
        test_counter_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Downstream drain stage for the synchronous FIFO. It pulls words through the FIFO's read port, which has a registered read with 1-cycle latency, and presents them on a valid/ready stream. It absorbs the read latency with a 3-entry internal buffer, so it sustains one word per cycle with no combinational path from `m_ready` to `fifo_r_en`. Data order is strictly preserved.

## Interface
- `DATA_WIDTH`, 8, word width on both the FIFO side and the stream side.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; clears all state immediately.
- `fifo_empty`  in  1  empty flag from the FIFO.
- `fifo_r_en`  out  1  read strobe to the FIFO.
- `fifo_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after `fifo_r_en`.
- `m_valid`  out  1  the stream word on `m_data` is valid.
- `m_ready`  in  1  the consumer accepts the word.
- `m_data`  out  DATA_WIDTH  stream data, taken from the head of the buffer.
- `xfer_cnt`  out  16  handshake counter; present only with `FIFO_RD_XFER_CNT_EN`.

## Operation
- **State registers**
  - `occ` (0..3): buffered words.
  - `inflight` (0/1): registered copy of last cycle's `fifo_r_en`.
  - A 3-entry circular buffer with 2-bit head and tail pointers, each wrapping 2 -> 0.
- **Read issue**
  - `fifo_r_en = rst & !fifo_empty & (occ + inflight <= 2)`.
  - This depends only on registers and `fifo_empty`.
  - It is never asserted while `fifo_empty` is high.
- **Capture:** when `inflight == 1`, `fifo_data` is written at the tail and the tail advances.
- **Pop:** when `m_valid & m_ready`, the head advances.
- **Occupancy update:** `occ_next = occ + inflight - pop`.
  - Capture and pop in the same cycle leave `occ` unchanged.
  - Pop with `occ == 1` and a simultaneous capture: the captured word becomes the head next cycle.
- **Output:** `m_valid = (occ != 0)`; `m_data = buf[head]`.
- **Stream rules**
  - Once `m_valid` is high, `m_valid` and `m_data` stay stable until the handshake.
  - `m_ready` may toggle freely; `m_ready` with `m_valid` low has no effect.
- **Overflow:** `occ + inflight <= 2` at issue time guarantees `occ <= 3` always, so a capture can never hit a full buffer.
- **FIFO-side invariant:** the block never relies on the FIFO ignoring reads when empty.
- **Reset mid-operation:** buffered and in-flight words are discarded, and `occ`, `inflight` and the pointers return to 0. The upstream FIFO is reset by the same `rst`.

## Timing
- **Reset values:** `fifo_r_en` 0, `m_valid` 0, `m_data` 0, `xfer_cnt` 0; buffer contents are cleared to 0.
- **Fill latency** (idle block, `fifo_empty` falls at cycle 0):
  - `fifo_r_en` high in cycle 0.
  - `fifo_data` captured at the end of cycle 1.
  - `m_valid` high in cycle 2.
- **Throughput:** with the FIFO non-empty and `m_ready` held high, one handshake per cycle. Steady state is `occ = 1`, `inflight = 1`.
- **Backpressure:** with `m_ready` low, reads stop once `occ + inflight = 3`. At most 3 words are buffered.
- **Release:** when `m_ready` rises, reads resume on the first cycle in which `occ + inflight <= 2`. There is no bubble once the buffer is full.

## Configuration
- **`FIFO_RD_XFER_CNT_EN` defined**
  - Adds output `xfer_cnt[15:0]`.
  - It increments on every `m_valid & m_ready` cycle and wraps 0xFFFF -> 0x0000.
  - It is cleared asynchronously by `rst`.
- **Undefined:** the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- **Reset and single word:** release reset with `fifo_empty = 1`; all outputs stay 0. FIFO holds 0xA5 and `m_ready = 1`: `fifo_r_en` pulses one cycle, then `m_valid`/`m_data = 0xA5` appears exactly 2 cycles after the read.
- **Streaming:** FIFO pre-filled with 0x01..0x08, `m_ready = 1` throughout -> 8 consecutive handshake cycles carrying 0x01..0x08 in order, with no gaps after the first.
- **Backpressure:** same fill, `m_ready = 0` for 10 cycles -> exactly 3 `fifo_r_en` pulses, `m_valid` high, `m_data = 0x01` held stable. Then `m_ready = 1` -> 0x01..0x08 delivered with no loss or duplication.
- **Empty boundary:** FIFO holds 2 words while `m_ready` toggles 1,0,1,0 -> `fifo_r_en` is never asserted while `fifo_empty = 1`, and exactly 2 handshakes occur.
- **Reset mid-operation:** assert `rst` asynchronously between clock edges with `occ = 2` and `inflight = 1` -> `m_valid`, `fifo_r_en` and `xfer_cnt` go to 0 immediately. After release the block refills cleanly from new FIFO contents.
- **Counter wrap** (macro defined): force `xfer_cnt` to 0xFFFE, then perform 3 handshakes -> `xfer_cnt` reads 0xFFFF, 0x0000, 0x0001.
